// File: rtl/ravenoc_pkg.sv
// Shared router types: flit layout, direction encoding, request/response packing
// and the XY route helpers used by the ingress stage.
package ravenoc_pkg;

  localparam int FlitWidth    = 34;
  localparam int NumVirtChn   = 3;
  localparam int VcWidth      = $clog2(NumVirtChn);
  localparam int XWidth       = 1;
  localparam int YWidth       = 1;
  localparam int PktWidth     = 8;
  localparam int FlitTpWidth  = 2;
  localparam int MinDataWidth = FlitWidth - FlitTpWidth;
  localparam int NumOutputs   = 4;
  localparam bit ZeroHighPrior = 1'b1;

  localparam int XPos  = MinDataWidth - 1;
  localparam int YPos  = XPos - XWidth;
  localparam int SzPos = YPos - YWidth;

  typedef enum logic [1:0] {
    HEAD = 2'b00,
    BODY = 2'b01,
    TAIL = 2'b10
  } flit_type_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } dir_t;

  typedef struct packed {
    flit_type_t                                       ftype;
    logic [XWidth-1:0]                                x_dest;
    logic [YWidth-1:0]                                y_dest;
    logic [PktWidth-1:0]                              pkt_size;
    logic [MinDataWidth-XWidth-YWidth-PktWidth-1:0]   rsvd;
  } s_flit_head_t;

  typedef struct packed {
    logic [FlitWidth-1:0] fdata;
    logic [VcWidth-1:0]   vc_id;
    logic                 valid;
  } s_flit_req_t;

  typedef struct packed {
    logic [NumVirtChn-1:0] ready;
  } s_flit_resp_t;

  localparam int ReqWidth = $bits(s_flit_req_t);

  function automatic logic is_head(input logic [FlitWidth-1:0] f);
    return f[FlitWidth-1 -: FlitTpWidth] == HEAD;
  endfunction

  function automatic logic is_tail(input logic [FlitWidth-1:0] f);
    return f[FlitWidth-1 -: FlitTpWidth] == TAIL;
  endfunction

  function automatic logic is_single(input logic [FlitWidth-1:0] f);
    return is_head(f) && (f[SzPos -: PktWidth] == '0);
  endfunction

  // X is resolved before Y, so packets never turn back from Y into X.
  function automatic dir_t xy_route(input logic [XWidth-1:0] dx, input logic [YWidth-1:0] dy,
                                    input logic [XWidth-1:0] rx, input logic [YWidth-1:0] ry);
    dir_t d;
    d = LOCAL;
    if (dx > rx)      d = EAST;
    else if (dx < rx) d = WEST;
    else if (dy > ry) d = SOUTH;
    else if (dy < ry) d = NORTH;
    return d;
  endfunction

  function automatic dir_t flit_route(input logic [FlitWidth-1:0] f,
                                      input logic [XWidth-1:0] rx, input logic [YWidth-1:0] ry);
    return xy_route(f[XPos -: XWidth], f[YPos -: YWidth], rx, ry);
  endfunction

  function automatic logic [1:0] out_index(input dir_t d, input dir_t in_dir);
    logic [2:0] dv;
    dv = d;
    return (d > in_dir) ? 2'(dv - 3'd1) : 2'(dv);
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Synchronous FIFO for one virtual channel; the head entry is always visible on data_o.
module vc_fifo
  import ravenoc_pkg::*;
#(
  parameter int WIDTH = FlitWidth,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = (wr_i && !full_o)  ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
  assign rd_ptr_d = (rd_i && !empty_o) ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/input_router_vc.sv
// Router ingress port: per-VC buffering, XY route hold per packet, and per-output
// fixed-priority VC selection towards the four output arbiters.
module input_router_vc
  import ravenoc_pkg::*;
#(
  parameter logic [XWidth-1:0] ROUTER_X   = '0,
  parameter logic [YWidth-1:0] ROUTER_Y   = '0,
  parameter int                IN_DIR     = 0,
  parameter int                BUFF_DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                arst,
  input  logic [ReqWidth-1:0]                 fin_req_i,
  output logic [NumVirtChn-1:0]               fin_resp_o,
  output logic [NumOutputs-1:0][ReqWidth-1:0] fout_req_o,
  input  logic [NumOutputs-1:0]               fout_resp_i
);
  typedef enum logic [1:0] {VC_IDLE, VC_ROUTED, VC_DRAIN} vc_state_t;

  localparam dir_t InDir = dir_t'(IN_DIR[2:0]);

  s_flit_req_t                           fin_req;
  logic [NumVirtChn-1:0]                 push, pop, full, empty, pres, drop;
  logic [NumVirtChn-1:0][FlitWidth-1:0]  head_flit;
  logic [NumVirtChn-1:0][1:0]            oidx;
  dir_t                                  rt_comb [NumVirtChn];
  dir_t                                  sel_dir [NumVirtChn];
  vc_state_t                             st_q    [NumVirtChn];
  vc_state_t                             st_d    [NumVirtChn];
  dir_t                                  route_q [NumVirtChn];
  dir_t                                  route_d [NumVirtChn];
  logic [NumOutputs-1:0]                 win_vld;
  logic [NumOutputs-1:0][VcWidth-1:0]    win_vc;

  assign fin_req    = s_flit_req_t'(fin_req_i);
  assign fin_resp_o = ~full;

  for (genvar v = 0; v < NumVirtChn; v++) begin : g_vc
    assign push[v] = fin_req.valid && (fin_req.vc_id == VcWidth'(v)) && !full[v];

    vc_fifo #(
      .WIDTH (FlitWidth),
      .DEPTH (BUFF_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .wr_i    (push[v]),
      .data_i  (fin_req.fdata),
      .rd_i    (pop[v]),
      .data_o  (head_flit[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  // Per-VC decision on the FIFO head: present to an output, or discard it.
  always_comb begin
    for (int v = 0; v < NumVirtChn; v++) begin
      rt_comb[v] = flit_route(head_flit[v], ROUTER_X, ROUTER_Y);
      sel_dir[v] = rt_comb[v];
      pres[v]    = 1'b0;
      drop[v]    = 1'b0;
      if (!empty[v]) begin
        unique case (st_q[v])
          VC_IDLE: begin
            if (!is_head(head_flit[v]) || rt_comb[v] == InDir) drop[v] = 1'b1;
            else                                               pres[v] = 1'b1;
          end
          VC_ROUTED: begin
            if (!is_head(head_flit[v])) begin
              pres[v]    = 1'b1;
              sel_dir[v] = route_q[v];
            end
          end
          VC_DRAIN: drop[v] = !is_head(head_flit[v]);
          default: ;
        endcase
      end
      oidx[v] = out_index(sel_dir[v], InDir);
    end
  end

  // Lowest VC index wins each output.
  always_comb begin
    win_vld = '0;
    win_vc  = '0;
    for (int o = 0; o < NumOutputs; o++) begin
      for (int v = 0; v < NumVirtChn; v++) begin
        if (!win_vld[o] && pres[v] && oidx[v] == 2'(o)) begin
          win_vld[o] = 1'b1;
          win_vc[o]  = VcWidth'(v);
        end
      end
    end
    pop = drop;
    for (int v = 0; v < NumVirtChn; v++) begin
      for (int o = 0; o < NumOutputs; o++) begin
        if (win_vld[o] && win_vc[o] == VcWidth'(v) && fout_resp_i[o]) pop[v] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NumOutputs; o++) begin
      fout_req_o[o] = win_vld[o] ? {head_flit[win_vc[o]], win_vc[o], 1'b1} : '0;
    end
  end

  // A HEAD met mid-packet abandons the old route; the flit is re-examined from IDLE.
  always_comb begin
    for (int v = 0; v < NumVirtChn; v++) begin
      st_d[v]    = st_q[v];
      route_d[v] = route_q[v];
      if (!empty[v]) begin
        unique case (st_q[v])
          VC_IDLE: begin
            if (pop[v] && is_head(head_flit[v])) begin
              if (rt_comb[v] == InDir) begin
                st_d[v] = is_single(head_flit[v]) ? VC_IDLE : VC_DRAIN;
              end else if (!is_single(head_flit[v])) begin
                st_d[v]    = VC_ROUTED;
                route_d[v] = rt_comb[v];
              end
            end
          end
          VC_ROUTED, VC_DRAIN: begin
            if (is_head(head_flit[v]))                 st_d[v] = VC_IDLE;
            else if (pop[v] && is_tail(head_flit[v]))  st_d[v] = VC_IDLE;
          end
          default: st_d[v] = VC_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < NumVirtChn; v++) begin
        st_q[v]    <= VC_IDLE;
        route_q[v] <= LOCAL;
      end
    end else begin
      for (int v = 0; v < NumVirtChn; v++) begin
        st_q[v]    <= st_d[v];
        route_q[v] <= route_d[v];
      end
    end
  end

endmodule

// File: tb/tb_input_router_vc.sv
// Scoreboard bench for input_router_vc: directed scenarios followed by random traffic,
// with a packet-level reference model feeding per-output/per-VC expectation queues.
module tb_input_router_vc;

  // Facing WEST keeps the LOCAL output present while EAST still lands on index 3.
  localparam int IN_DIR = 3;
  localparam bit RX = 1'b0;
  localparam bit RY = 1'b0;

  logic            clk;
  logic            arst;
  logic [36:0]     fin_req_i;
  logic [2:0]      fin_resp_o;
  logic [3:0][36:0] fout_req_o;
  logic [3:0]      fout_resp_i;

  int total = 0;
  int bad   = 0;

  logic [33:0] exp_q [4][3][$];
  bit          m_inpkt [3];
  bit          m_drain [3];
  int          m_route [3];

  input_router_vc #(
    .ROUTER_X   (RX),
    .ROUTER_Y   (RY),
    .IN_DIR     (IN_DIR),
    .BUFF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .arst        (arst),
    .fin_req_i   (fin_req_i),
    .fin_resp_o  (fin_resp_o),
    .fout_req_o  (fout_req_o),
    .fout_resp_i (fout_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [33:0] hd(bit dx, bit dy, int sz, int data);
    return {2'b00, dx, dy, 8'(sz), 22'(data)};
  endfunction
  function automatic logic [33:0] body(int data);
    return {2'b01, 32'(data)};
  endfunction
  function automatic logic [33:0] tail(int data);
    return {2'b10, 32'(data)};
  endfunction

  function automatic int route_of(bit dx, bit dy);
    if (dx > RX) return 4;
    if (dx < RX) return 3;
    if (dy > RY) return 2;
    if (dy < RY) return 1;
    return 0;
  endfunction

  function automatic int out_of(int dir);
    return (dir < IN_DIR) ? dir : dir - 1;
  endfunction

  function automatic void model_reset();
    for (int o = 0; o < 4; o++)
      for (int v = 0; v < 3; v++) exp_q[o][v].delete();
    for (int v = 0; v < 3; v++) begin
      m_inpkt[v] = 1'b0;
      m_drain[v] = 1'b0;
      m_route[v] = 0;
    end
  endfunction

  // Packet-level meaning of one accepted flit on one VC.
  function automatic void model_push(int vc, logic [33:0] f);
    int dir;
    if (vc > 2) return;
    if (f[33:32] == 2'b00) begin
      dir = route_of(f[31], f[30]);
      m_inpkt[vc] = 1'b0;
      m_drain[vc] = 1'b0;
      if (dir == IN_DIR) begin
        m_drain[vc] = (f[29:22] != 0);
      end else begin
        exp_q[out_of(dir)][vc].push_back(f);
        m_inpkt[vc] = (f[29:22] != 0);
        m_route[vc] = dir;
      end
    end else if (m_inpkt[vc]) begin
      exp_q[out_of(m_route[vc])][vc].push_back(f);
      if (f[33:32] == 2'b10) m_inpkt[vc] = 1'b0;
    end else if (m_drain[vc]) begin
      if (f[33:32] == 2'b10) m_drain[vc] = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int vc, input logic [33:0] f);
    int n = 0;
    while (!fin_resp_o[vc] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!fin_resp_o[vc]) begin
      total++;
      bad++;
      $display("FAIL send_timeout vc%0d: ready got 0, required 1", vc);
      return;
    end
    fin_req_i = {f, 2'(vc), 1'b1};
    model_push(vc, f);
    @(posedge clk);
    #1;
    fin_req_i = '0;
  endtask

  // Monitor: every handshake on an output must match the oldest expected flit for that VC.
  always @(negedge clk) begin
    logic [36:0] r;
    logic [33:0] e;
    int          vc;
    if (!arst) begin
      if (fin_req_i[0] && fin_req_i[2:1] != 2'd3) begin
        total++;
        if (!fin_resp_o[fin_req_i[2:1]]) begin
          bad++;
          $display("FAIL ingress_ready vc%0d: ready got 0 while valid, required 1", fin_req_i[2:1]);
        end
      end
      for (int o = 0; o < 4; o++) begin
        r = fout_req_o[o];
        if (!r[0]) begin
          total++;
          if (r != '0) begin
            bad++;
            $display("FAIL idle_zero out%0d: got %0h, required 0", o, r);
          end
        end else if (fout_resp_i[o]) begin
          vc = int'(r[2:1]);
          total++;
          if (vc > 2) begin
            bad++;
            $display("FAIL sb_vc out%0d: got vc=%0d, required vc<3", o, vc);
          end else if (exp_q[o][vc].size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected out%0d vc%0d: got flit %0h, required none", o, vc, r[36:3]);
          end else begin
            e = exp_q[o][vc].pop_front();
            if (r[36:3] !== e) begin
              bad++;
              $display("FAIL sb_flit out%0d vc%0d: got %0h, required %0h", o, vc, r[36:3], e);
            end
          end
        end
      end
    end
  end

  function automatic logic [33:0] rand_flit();
    int r;
    r = $urandom_range(0, 99);
    if (r < 40) return hd(1'($urandom), 1'($urandom), $urandom_range(0, 3), int'($urandom));
    if (r < 75) return body(int'($urandom));
    return tail(int'($urandom));
  endfunction

  initial begin
    int vc;
    logic [33:0] f;
    arst        = 1'b1;
    fin_req_i   = '0;
    fout_resp_i = '0;
    model_reset();
    #1;
    chk("reset_fout", 64'(|fout_req_o), 64'd0);
    chk("reset_ready", 64'(fin_resp_o), 64'h7);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    fout_resp_i = 4'hF;

    // three-flit packet east on VC1
    send(1, hd(1, 0, 2, 'h11));
    chk("t1_head_tag", 64'(fout_req_o[3][2:0]), 64'h3);
    chk("t1_head_flit", 64'(fout_req_o[3][36:3]), 64'(hd(1, 0, 2, 'h11)));
    send(1, body('h12));
    chk("t1_body_flit", 64'(fout_req_o[3][36:3]), 64'(body('h12)));
    send(1, tail('h13));
    chk("t1_tail_flit", 64'(fout_req_o[3][36:3]), 64'(tail('h13)));
    send(1, hd(0, 1, 0, 'h14));
    chk("t1_idle_after_tail", 64'(fout_req_o[2][2:0]), 64'h3);

    // single-flit packets on VC0, routed independently
    send(0, hd(0, 0, 0, 'h21));
    chk("t2_local_tag", 64'(fout_req_o[0][2:0]), 64'h1);
    chk("t2_local_flit", 64'(fout_req_o[0][36:3]), 64'(hd(0, 0, 0, 'h21)));
    send(0, hd(1, 0, 0, 'h22));
    chk("t2_east_tag", 64'(fout_req_o[3][2:0]), 64'h1);
    chk("t2_local_gone", 64'(fout_req_o[0][0]), 64'd0);
    idle(3);

    // VC2 fills while outputs stall
    fout_resp_i = 4'h0;
    send(2, hd(1, 0, 2, 'h31));
    send(2, body('h32));
    chk("t3_full_ready", 64'(fin_resp_o), 64'h3);
    idle(3);
    chk("t3_held", 64'(fin_resp_o[2]), 64'd0);
    chk("t3_head_wait", 64'(fout_req_o[3][36:3]), 64'(hd(1, 0, 2, 'h31)));
    fout_resp_i = 4'hF;
    idle(1);
    chk("t3_ready_back", 64'(fin_resp_o), 64'h7);
    chk("t3_body_next", 64'(fout_req_o[3][36:3]), 64'(body('h32)));
    send(2, tail('h33));
    idle(3);

    // VC0 and VC1 compete for SOUTH, VC2 goes EAST
    fout_resp_i = 4'h0;
    send(0, hd(0, 1, 1, 'h41));
    send(1, hd(0, 1, 1, 'h42));
    send(2, hd(1, 0, 0, 'h43));
    chk("t4_south_vc0", 64'(fout_req_o[2][2:0]), 64'h1);
    chk("t4_east_vc2", 64'(fout_req_o[3][2:0]), 64'h5);
    fout_resp_i = 4'b1100;
    idle(1);
    fout_resp_i = 4'h0;
    chk("t4_south_vc1", 64'(fout_req_o[2][2:0]), 64'h3);
    chk("t4_east_done", 64'(fout_req_o[3][0]), 64'd0);
    send(0, tail('h44));
    chk("t4_vc0_again", 64'(fout_req_o[2][2:0]), 64'h1);
    fout_resp_i = 4'hF;
    send(1, tail('h45));
    idle(4);

    // reset in the middle of a packet
    fout_resp_i = 4'h0;
    send(1, hd(1, 0, 3, 'h51));
    send(1, body('h52));
    chk("t5_pre_valid", 64'(fout_req_o[3][0]), 64'd1);
    arst = 1'b1;
    model_reset();
    #1;
    chk("t5_rst_fout", 64'(|fout_req_o), 64'd0);
    chk("t5_rst_ready", 64'(fin_resp_o), 64'h7);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
    fout_resp_i = 4'hF;
    send(1, hd(0, 1, 0, 'h53));
    chk("t5_after_rst", 64'(fout_req_o[2][2:0]), 64'h3);
    idle(3);

    // orphan BODY is discarded and frees its slot
    fout_resp_i = 4'h0;
    send(0, body('h61));
    idle(2);
    send(0, hd(0, 1, 1, 'h62));
    send(0, body('h63));
    chk("t6_full", 64'(fin_resp_o[0]), 64'd0);
    chk("t6_head_flit", 64'(fout_req_o[2][36:3]), 64'(hd(0, 1, 1, 'h62)));
    chk("t6_head_tag", 64'(fout_req_o[2][2:0]), 64'h1);
    fout_resp_i = 4'hF;
    send(0, tail('h64));
    idle(4);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      fout_resp_i = 4'($urandom);
      if ($urandom_range(0, 9) < 7) begin
        vc = $urandom_range(0, 3);
        f  = rand_flit();
        if (vc == 3) begin
          fin_req_i = {f, 2'd3, 1'b1};
        end else if (fin_resp_o[vc]) begin
          fin_req_i = {f, 2'(vc), 1'b1};
          model_push(vc, f);
        end
      end
      @(posedge clk);
      #1;
      fin_req_i = '0;
    end
    fout_resp_i = 4'hF;
    idle(40);
    for (int o = 0; o < 4; o++) begin
      for (int v = 0; v < 3; v++) begin
        total++;
        if (exp_q[o][v].size() != 0) begin
          bad++;
          $display("FAIL drain out%0d vc%0d: got %0d pending, required 0", o, v, exp_q[o][v].size());
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
